// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// FSM state encodings, PC redirect codes and the decoded instruction class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  // ALU op class: add (address / PC+4), subtract (compare), funct-driven, immediate logic
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_WB     = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILL
  } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier for the multicycle controller.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls = CLS_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLT: cls = CLS_RTYPE;
          FN_JR:                    cls = CLS_JR;
          default:                  cls = CLS_ILL;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with a combinational decode sub-block.
// Optional RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic [1:0]  PCWr,
  output logic        PCEn,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic        ALUSrcA,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
`ifdef RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic        illegal
);

  state_t       state_reg;
  state_t       state_next;
  instr_class_t cls;
  logic         dec_illegal;

  ctrl_decode u_decode (
    .op      (op),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (cls)
          CLS_LW, CLS_SW:             state_next = S_MEMADR;
          CLS_RTYPE, CLS_ORI, CLS_LUI: state_next = S_EXE;
          CLS_BEQ, CLS_BNE:           state_next = S_BRANCH;
          CLS_J, CLS_JAL, CLS_JR:     state_next = S_JUMP;
          default:                    state_next = S_FETCH;
        endcase
      end
      S_EXE:    state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_MEMADR: state_next = (cls == CLS_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = mem_rdy ? S_FETCH : S_MEMWR;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Everything is held low while rst is high so no strobe can fire in a reset cycle.
  always_comb begin
    PCWr     = PC_SEQ;
    PCEn     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    ALUSrcA  = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = ALUOP_ADD;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          MemRd   = 1'b1;
          IRWr    = mem_rdy;
          ALUSrcB = 2'b01;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          illegal = dec_illegal;
          PCEn    = dec_illegal;
        end
        S_EXE: begin
          ALUSrcA = 1'b1;
          if (cls == CLS_RTYPE) begin
            ALUSrcB = 2'b00;
            ALUOp   = ALUOP_FUNCT;
          end else begin
            ALUSrcB = 2'b10;
            ALUOp   = ALUOP_IMM;
          end
        end
        S_WB: begin
          RegWr  = 1'b1;
          PCEn   = 1'b1;
          RegDst = (cls == CLS_RTYPE) ? 2'b01 : 2'b00;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: MemRd = 1'b1;
        S_MEMWB: begin
          RegWr    = 1'b1;
          MemtoReg = 2'b01;
          PCEn     = 1'b1;
        end
        S_MEMWR: begin
          MemWr = 1'b1;
          PCEn  = mem_rdy;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_SUB;
          PCEn    = 1'b1;
          if ((cls == CLS_BEQ && zero) || (cls == CLS_BNE && !zero)) PCWr = PC_BR;
        end
        S_JUMP: begin
          PCEn = 1'b1;
          PCWr = (cls == CLS_JR) ? PC_REG : PC_JMP;
          if (cls == CLS_JAL) begin
            RegWr    = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_reg;

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)       retire_cnt_reg <= 32'd0;
    else if (PCEn) retire_cnt_reg <= retire_cnt_reg + 32'd1;
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours RETIRE_CNT_EN when defined.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_rdy;
  logic [1:0]  PCWr;
  logic        PCEn, IRWr, RegWr, MemRd, MemWr, ALUSrcA, illegal;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, ALUOp;
  logic [3:0]  state;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  int unsigned exp_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] strb_vec;
  logic [8:0] sel_vec;
  assign strb_vec = {PCWr, PCEn, IRWr, RegWr, MemRd, MemWr, illegal};
  assign sel_vec  = {ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .PCEn(PCEn), .IRWr(IRWr), .RegWr(RegWr), .MemRd(MemRd), .MemWr(MemWr),
    .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state),
`ifdef RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe bits: {PCWr[1:0],PCEn,IRWr,RegWr,MemRd,MemWr,illegal}
  // select bits: {ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],RegDst[1:0],MemtoReg[1:0]}
  task automatic step(input string tag, input logic [3:0] es, input logic [7:0] estr,
                      input logic [8:0] esel);
    #1;
    chk({tag, "/state"}, 32'(state), 32'(es));
    chk({tag, "/strb"}, 32'(strb_vec), 32'(estr));
    chk({tag, "/sel"}, 32'(sel_vec), 32'(esel));
`ifdef RETIRE_CNT_EN
    chk({tag, "/cnt"}, retire_cnt, exp_cnt);
    if (rst) exp_cnt = 0;
    else if (estr[5]) exp_cnt++;
`endif
    $display("step %-12s state=%0d strb=%02h sel=%03h", tag, state, strb_vec, sel_vec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 4'd0, 8'h00, 9'h000);
    rst = 1'b0;

    // addu: 0,1,2,7 with retire in the 4th cycle
    op = 6'b000000; funct = 6'b100001;
    step("addu_f", 4'd0, 8'h14, 9'h040);
    step("addu_d", 4'd1, 8'h00, 9'h0C0);
    step("addu_e", 4'd2, 8'h00, 9'h120);
    step("addu_wb", 4'd7, 8'h28, 9'h004);

    // fetch stall, then ori
    op = 6'b001101; mem_rdy = 1'b0;
    step("stall_f", 4'd0, 8'h04, 9'h040);
    mem_rdy = 1'b1;
    step("ori_f", 4'd0, 8'h14, 9'h040);
    step("ori_d", 4'd1, 8'h00, 9'h0C0);
    step("ori_e", 4'd2, 8'h00, 9'h1B0);
    step("ori_wb", 4'd7, 8'h28, 9'h000);

    // lw with three wait cycles in MEMRD
    op = 6'b100011;
    step("lw_f", 4'd0, 8'h14, 9'h040);
    step("lw_d", 4'd1, 8'h00, 9'h0C0);
    step("lw_a", 4'd3, 8'h00, 9'h180);
    mem_rdy = 1'b0;
    step("lw_rd0", 4'd4, 8'h04, 9'h000);
    step("lw_rd1", 4'd4, 8'h04, 9'h000);
    step("lw_rd2", 4'd4, 8'h04, 9'h000);
    mem_rdy = 1'b1;
    step("lw_rd3", 4'd4, 8'h04, 9'h000);
    step("lw_wb", 4'd5, 8'h28, 9'h001);

    // sw, no wait
    op = 6'b101011;
    step("sw_f", 4'd0, 8'h14, 9'h040);
    step("sw_d", 4'd1, 8'h00, 9'h0C0);
    step("sw_a", 4'd3, 8'h00, 9'h180);
    step("sw_wr", 4'd6, 8'h22, 9'h000);

    // branches: taken codes are 0x60, not-taken 0x20
    op = 6'b000100; zero = 1'b1;
    step("beq1_f", 4'd0, 8'h14, 9'h040);
    step("beq1_d", 4'd1, 8'h00, 9'h0C0);
    step("beq1_b", 4'd8, 8'h60, 9'h110);
    zero = 1'b0;
    step("beq0_f", 4'd0, 8'h14, 9'h040);
    step("beq0_d", 4'd1, 8'h00, 9'h0C0);
    step("beq0_b", 4'd8, 8'h20, 9'h110);
    op = 6'b000101; zero = 1'b1;
    step("bne1_f", 4'd0, 8'h14, 9'h040);
    step("bne1_d", 4'd1, 8'h00, 9'h0C0);
    step("bne1_b", 4'd8, 8'h20, 9'h110);
    zero = 1'b0;
    step("bne0_f", 4'd0, 8'h14, 9'h040);
    step("bne0_d", 4'd1, 8'h00, 9'h0C0);
    step("bne0_b", 4'd8, 8'h60, 9'h110);

    // jumps
    op = 6'b000011;
    step("jal_f", 4'd0, 8'h14, 9'h040);
    step("jal_d", 4'd1, 8'h00, 9'h0C0);
    step("jal_j", 4'd9, 8'hA8, 9'h00A);
    op = 6'b000000; funct = 6'b001000;
    step("jr_f", 4'd0, 8'h14, 9'h040);
    step("jr_d", 4'd1, 8'h00, 9'h0C0);
    step("jr_j", 4'd9, 8'hE0, 9'h000);
    op = 6'b000010;
    step("j_f", 4'd0, 8'h14, 9'h040);
    step("j_d", 4'd1, 8'h00, 9'h0C0);
    step("j_j", 4'd9, 8'hA0, 9'h000);

    // illegal opcode and illegal funct both retire from DECODE
    op = 6'b111111;
    step("ill_f", 4'd0, 8'h14, 9'h040);
    step("ill_d", 4'd1, 8'h21, 9'h0C0);
    op = 6'b000000; funct = 6'b000000;
    step("illf_f", 4'd0, 8'h14, 9'h040);
    step("illf_d", 4'd1, 8'h21, 9'h0C0);

    // reset while MEMWR is stalled: access abandoned, no retire
    op = 6'b101011;
    step("swr_f", 4'd0, 8'h14, 9'h040);
    step("swr_d", 4'd1, 8'h00, 9'h0C0);
    step("swr_a", 4'd3, 8'h00, 9'h180);
    mem_rdy = 1'b0;
    step("swr_wr", 4'd6, 8'h02, 9'h000);
    rst = 1'b1;
    step("swr_rst", 4'd6, 8'h00, 9'h000);
    step("swr_post", 4'd0, 8'h00, 9'h000);
    rst = 1'b0; mem_rdy = 1'b1; op = 6'b000000; funct = 6'b100011;
    step("subu_f", 4'd0, 8'h14, 9'h040);
    step("subu_d", 4'd1, 8'h00, 9'h0C0);
    step("subu_e", 4'd2, 8'h00, 9'h120);
    step("subu_wb", 4'd7, 8'h28, 9'h004);
    step("end_f", 4'd0, 8'h14, 9'h040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
